pa_fpu_wbsched: RTL and testbench
=================================

PA_FPU_WBSCHED -- requirements
Module: pa_fpu_wbsched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning cycles of denied fdsu request before fdsu gets top priority (range 1..15).
REQ-002 SHALL have port forever_cpuclk  input  1  sole clock; all flops rising-edge.
REQ-003 SHALL have port cpurst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports fdsu_req/ex2_req/ex3_req/ex4_req  input  1 each  writeback request per source.
REQ-005 SHALL have ports <src>_freg  input  5, <src>_data  input  32, <src>_fflags  input  5, per source.
REQ-006 SHALL have ports fdsu_grant/ex2_grant/ex3_grant/ex4_grant  output  1 each  same-cycle acceptance of that source's payload.
REQ-007 SHALL have port rtu_fpu_fgpr_wb_grant  input  1  RTU consumes the current writeback slot this cycle.
REQ-008 SHALL have ports fpu_rtu_fgpr_wb_vld  output  1, fpu_rtu_fgpr_wb_reg  output  5, fpu_rtu_fgpr_wb_data  output  32  registered writeback slot.
REQ-009 SHALL have ports fpu_cp0_wb_fflags_updt  output  1, fpu_cp0_wb_fflags  output  5  registered fflags commit pulse.

Function
REQ-010 SHALL hold one writeback slot register (vld, reg, data, fflags); slot_free = !slot_vld || rtu_fpu_fgpr_wb_grant.
REQ-011 SHALL assert at most one grant per cycle, and only when slot_free and that source's req are high; grants are combinational from req, slot state and boost.
REQ-012 SHALL use priority ex4 > ex3 > ex2 > fdsu when boost is low.
REQ-013 SHALL place fdsu above all others when boost is high and fdsu_req is high.
REQ-014 SHALL load the granted source's freg/data/fflags into the slot at the next edge and set slot_vld=1 (latency: grant cycle N -> fpu_rtu_fgpr_wb_vld in N+1).
REQ-015 SHALL clear slot_vld when rtu_fpu_fgpr_wb_grant=1 and no source is granted that cycle; SHALL keep slot contents stable while slot_vld=1 and RTU grant=0.
REQ-016 SHALL, on simultaneous drain and new grant, overwrite the slot with the new payload and keep slot_vld=1 (back-to-back throughput one per cycle).
REQ-017 SHALL maintain a 4-bit starvation counter: +1 each cycle fdsu_req=1 and fdsu_grant=0, saturating at STARVE_LIMIT; cleared to 0 on fdsu_grant or fdsu_req=0.
REQ-018 SHALL drive boost = (counter == STARVE_LIMIT).
REQ-019 SHALL, one cycle after slot_vld && rtu_fpu_fgpr_wb_grant, pulse fpu_cp0_wb_fflags_updt=1 for one cycle with fpu_cp0_wb_fflags = fflags of the drained entry; otherwise updt=0 and fflags=0.
REQ-020 SHALL never assert a grant while slot_vld=1 and RTU grant=0 (full slot back-pressures all sources).

Reset
REQ-021 SHALL, while cpurst=1, force slot_vld=0, slot reg/data/fflags=0, counter=0, fpu_cp0_wb_fflags_updt=0, fpu_cp0_wb_fflags=0; all grants 0.
REQ-022 SHALL discard any in-flight slot entry on reset assertion mid-operation, with no fflags pulse afterwards.
REQ-023 SHALL accept requests on the first edge after cpurst deasserts.

Configuration
REQ-024 SHALL with macro FPU_WBSCHED_AGING_EN defined implement the counter and boost of REQ-013/017/018.
REQ-025 SHALL without FPU_WBSCHED_AGING_EN omit the counter, tie boost to 0, and use pure fixed priority; STARVE_LIMIT then has no effect.

Verification
REQ-026 SHALL cover: ex2_req+ex4_req together, RTU grant=1 -> ex4_grant=1, ex2_grant=0; next cycle wb_vld=1 with ex4 freg/data.
REQ-027 SHALL cover: slot full, RTU grant=0 for 3 cycles, ex3_req=1 -> no grant for 3 cycles, wb outputs stable; RTU grant=1 -> ex3_grant same cycle, slot replaced next cycle.
REQ-028 SHALL cover: AGING_EN, STARVE_LIMIT=8, fdsu_req held with ex2_req held every cycle -> fdsu_grant in cycle 9 (counter saturated), ex2 denied that cycle; counter returns to 0.
REQ-029 SHALL cover: drained entry with fflags=5'b00001 -> fpu_cp0_wb_fflags_updt=1, fpu_cp0_wb_fflags=5'b00001 exactly one cycle after drain, 0 the cycle after.
REQ-030 SHALL cover: cpurst asserted while slot_vld=1 -> wb_vld=0 asynchronously, no fflags pulse, counter=0; no AGING_EN build -> fdsu starves indefinitely under continuous ex2_req.

Source files
------------

// File: rtl/pa_fpu_wbsched.sv
// pa_fpu_wbsched
//   FPU register-file writeback scheduler. Four result sources (fdsu, ex2, ex3,
//   ex4) compete for a single registered writeback slot that is drained by the
//   RTU. Arbitration is fixed priority ex4 > ex3 > ex2 > fdsu. Optionally, an
//   aging counter lifts fdsu to top priority after it has been denied for
//   STARVE_LIMIT consecutive cycles.
//
//   Build option: define FPU_WBSCHED_AGING_EN to enable the fdsu aging counter.
//   Without it, arbitration is pure fixed priority and STARVE_LIMIT is ignored.
//
// Ports
//   forever_cpuclk               in   clock, rising edge
//   cpurst                       in   asynchronous active-high reset
//   <src>_req                    in   writeback request (src = fdsu/ex2/ex3/ex4)
//   <src>_freg/_data/_fflags     in   payload: 5b dest reg, 32b data, 5b flags
//   <src>_grant                  out  combinational same-cycle acceptance
//   rtu_fpu_fgpr_wb_grant        in   RTU consumes the slot this cycle
//   fpu_rtu_fgpr_wb_vld/reg/data out  registered writeback slot
//   fpu_cp0_wb_fflags_updt       out  one-cycle pulse after a slot drains
//   fpu_cp0_wb_fflags            out  fflags of the drained entry (0 otherwise)
module pa_fpu_wbsched #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,

  input  logic        fdsu_req,
  input  logic [4:0]  fdsu_freg,
  input  logic [31:0] fdsu_data,
  input  logic [4:0]  fdsu_fflags,
  output logic        fdsu_grant,

  input  logic        ex2_req,
  input  logic [4:0]  ex2_freg,
  input  logic [31:0] ex2_data,
  input  logic [4:0]  ex2_fflags,
  output logic        ex2_grant,

  input  logic        ex3_req,
  input  logic [4:0]  ex3_freg,
  input  logic [31:0] ex3_data,
  input  logic [4:0]  ex3_fflags,
  output logic        ex3_grant,

  input  logic        ex4_req,
  input  logic [4:0]  ex4_freg,
  input  logic [31:0] ex4_data,
  input  logic [4:0]  ex4_fflags,
  output logic        ex4_grant,

  input  logic        rtu_fpu_fgpr_wb_grant,
  output logic        fpu_rtu_fgpr_wb_vld,
  output logic [4:0]  fpu_rtu_fgpr_wb_reg,
  output logic [31:0] fpu_rtu_fgpr_wb_data,

  output logic        fpu_cp0_wb_fflags_updt,
  output logic [4:0]  fpu_cp0_wb_fflags
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("pa_fpu_wbsched: STARVE_LIMIT must be within 1..15");
  end

  logic        r_slot_vld;
  logic [4:0]  r_slot_reg;
  logic [31:0] r_slot_data;
  logic [4:0]  r_slot_fflags;
  logic        r_ff_updt;
  logic [4:0]  r_ff;

  logic        w_slot_free;
  logic        w_grant_en;
  logic        w_boost;
  logic        w_any_grant;
  logic        w_drain;
  logic [4:0]  w_ld_reg;
  logic [31:0] w_ld_data;
  logic [4:0]  w_ld_fflags;

  // The slot can take a new entry when empty or when RTU empties it this cycle.
  // Grants are also suppressed while reset is held.
  assign w_slot_free = !r_slot_vld || rtu_fpu_fgpr_wb_grant;
  assign w_grant_en  = w_slot_free && !cpurst;
  assign w_drain     = r_slot_vld && rtu_fpu_fgpr_wb_grant;

`ifdef FPU_WBSCHED_AGING_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;

  // Counts consecutive cycles fdsu asked and lost; any break in the request
  // or a win restarts the count.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_starve_cnt <= 4'd0;
    end else if (fdsu_req && !fdsu_grant) begin
      if (r_starve_cnt != LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

  assign w_boost = (r_starve_cnt == LIMIT);
`else
  assign w_boost = 1'b0;
`endif

  always_comb begin
    fdsu_grant = 1'b0;
    ex2_grant  = 1'b0;
    ex3_grant  = 1'b0;
    ex4_grant  = 1'b0;
    if (w_grant_en) begin
      if (w_boost && fdsu_req) begin
        fdsu_grant = 1'b1;
      end else if (ex4_req) begin
        ex4_grant = 1'b1;
      end else if (ex3_req) begin
        ex3_grant = 1'b1;
      end else if (ex2_req) begin
        ex2_grant = 1'b1;
      end else if (fdsu_req) begin
        fdsu_grant = 1'b1;
      end
    end
  end

  assign w_any_grant = fdsu_grant | ex2_grant | ex3_grant | ex4_grant;

  // Grants are one-hot, so a simple priority mux selects the payload.
  always_comb begin
    w_ld_reg    = 5'd0;
    w_ld_data   = 32'd0;
    w_ld_fflags = 5'd0;
    if (ex4_grant) begin
      w_ld_reg    = ex4_freg;
      w_ld_data   = ex4_data;
      w_ld_fflags = ex4_fflags;
    end else if (ex3_grant) begin
      w_ld_reg    = ex3_freg;
      w_ld_data   = ex3_data;
      w_ld_fflags = ex3_fflags;
    end else if (ex2_grant) begin
      w_ld_reg    = ex2_freg;
      w_ld_data   = ex2_data;
      w_ld_fflags = ex2_fflags;
    end else if (fdsu_grant) begin
      w_ld_reg    = fdsu_freg;
      w_ld_data   = fdsu_data;
      w_ld_fflags = fdsu_fflags;
    end
  end

  // Writeback slot: a new grant overwrites (even while draining, giving one
  // writeback per cycle); a drain with no new grant just invalidates.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_slot_vld    <= 1'b0;
      r_slot_reg    <= 5'd0;
      r_slot_data   <= 32'd0;
      r_slot_fflags <= 5'd0;
    end else if (w_any_grant) begin
      r_slot_vld    <= 1'b1;
      r_slot_reg    <= w_ld_reg;
      r_slot_data   <= w_ld_data;
      r_slot_fflags <= w_ld_fflags;
    end else if (rtu_fpu_fgpr_wb_grant) begin
      r_slot_vld    <= 1'b0;
    end
  end

  // fflags are committed to CP0 the cycle after the owning entry drains.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_ff_updt <= 1'b0;
      r_ff      <= 5'd0;
    end else begin
      r_ff_updt <= w_drain;
      r_ff      <= w_drain ? r_slot_fflags : 5'd0;
    end
  end

  assign fpu_rtu_fgpr_wb_vld    = r_slot_vld;
  assign fpu_rtu_fgpr_wb_reg    = r_slot_reg;
  assign fpu_rtu_fgpr_wb_data   = r_slot_data;
  assign fpu_cp0_wb_fflags_updt = r_ff_updt;
  assign fpu_cp0_wb_fflags      = r_ff;

endmodule

// File: tb/tb_pa_fpu_wbsched.sv
// Bench for pa_fpu_wbsched: directed table, hand-written corner sequences and a
// randomized run, all checked against a behavioural model of the scheduler.
// Source index: 0 = fdsu, 1 = ex2, 2 = ex3, 3 = ex4.
module tb_pa_fpu_wbsched;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        rtu;
  logic [4:0]  freg [4];
  logic [31:0] data [4];
  logic [4:0]  ff   [4];

  logic        fdsu_grant, ex2_grant, ex3_grant, ex4_grant;
  logic        wb_vld;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        updt;
  logic [4:0]  cp0_ff;
  logic [3:0]  g;

  assign g = {ex4_grant, ex3_grant, ex2_grant, fdsu_grant};

  always #5 clk = ~clk;

  pa_fpu_wbsched #(.STARVE_LIMIT(LIMIT)) dut (
    .forever_cpuclk         (clk),
    .cpurst                 (rst),
    .fdsu_req               (req[0]),
    .fdsu_freg              (freg[0]),
    .fdsu_data              (data[0]),
    .fdsu_fflags            (ff[0]),
    .fdsu_grant             (fdsu_grant),
    .ex2_req                (req[1]),
    .ex2_freg               (freg[1]),
    .ex2_data               (data[1]),
    .ex2_fflags             (ff[1]),
    .ex2_grant              (ex2_grant),
    .ex3_req                (req[2]),
    .ex3_freg               (freg[2]),
    .ex3_data               (data[2]),
    .ex3_fflags             (ff[2]),
    .ex3_grant              (ex3_grant),
    .ex4_req                (req[3]),
    .ex4_freg               (freg[3]),
    .ex4_data               (data[3]),
    .ex4_fflags             (ff[3]),
    .ex4_grant              (ex4_grant),
    .rtu_fpu_fgpr_wb_grant  (rtu),
    .fpu_rtu_fgpr_wb_vld    (wb_vld),
    .fpu_rtu_fgpr_wb_reg    (wb_reg),
    .fpu_rtu_fgpr_wb_data   (wb_data),
    .fpu_cp0_wb_fflags_updt (updt),
    .fpu_cp0_wb_fflags      (cp0_ff)
  );

  // Reference model state
  logic        m_vld;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [4:0]  m_ff;
  logic        m_updt;
  logic [4:0]  m_ffo;
  int          m_starved;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0] req;
    logic       rtu;
    logic [3:0] g;
    logic       vld;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_vld = 0; m_reg = 0; m_data = 0; m_ff = 0;
    m_updt = 0; m_ffo = 0; m_starved = 0;
  endfunction

  // Which source wins this cycle, -1 if none.
  function automatic int pick();
    if (rst) return -1;
    if (m_vld && !rtu) return -1;
`ifdef FPU_WBSCHED_AGING_EN
    if (m_starved >= LIMIT && req[0]) return 0;
`endif
    for (int s = 3; s >= 0; s--) if (req[s]) return s;
    return -1;
  endfunction

  // Drive one cycle of inputs after the falling edge, then compare all outputs.
  task automatic drive(input logic [3:0] r, input logic rt, input bit keep);
    int w;
    @(negedge clk);
    req = r;
    rtu = rt;
    if (!keep) begin
      for (int s = 0; s < 4; s++) begin
        freg[s] = 5'($urandom);
        data[s] = $urandom;
        ff[s]   = 5'($urandom);
      end
    end
    #1;
    w = pick();
    chk("grant", 32'(g), (w < 0) ? 32'd0 : (32'd1 << w));
    chk("wb_vld", 32'(wb_vld), 32'(m_vld));
    if (m_vld) begin
      chk("wb_reg", 32'(wb_reg), 32'(m_reg));
      chk("wb_data", wb_data, m_data);
    end
    chk("ff_updt", 32'(updt), 32'(m_updt));
    chk("ff_val", 32'(cp0_ff), 32'(m_ffo));
  endtask

  // Advance through the rising edge and update the model from pre-edge inputs.
  task automatic tick();
    int  w;
    logic drained;
    w = pick();
    drained = m_vld && rtu;
    @(posedge clk);
    m_updt = drained;
    m_ffo  = drained ? m_ff : 5'd0;
    if (w >= 0) begin
      m_vld = 1; m_reg = freg[w]; m_data = data[w]; m_ff = ff[w];
    end else if (rtu) begin
      m_vld = 0;
    end
    if (req[0] && w != 0) m_starved = (m_starved + 1 > LIMIT) ? LIMIT : m_starved + 1;
    else m_starved = 0;
  endtask

  task automatic cyc(input logic [3:0] r, input logic rt);
    drive(r, rt, 0);
    tick();
  endtask

  logic [4:0]  sv_reg;
  logic [31:0] sv_data;
  int          fdsu_wins;

  initial begin
    // {ex4,ex3,ex2,fdsu} requests, RTU grant, expected grants, expected wb_vld
    tbl[0] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[1] = '{4'b0010, 1'b0, 4'b0010, 1'b0};
    tbl[2] = '{4'b1010, 1'b0, 4'b0000, 1'b1};
    tbl[3] = '{4'b1010, 1'b1, 4'b1000, 1'b1};
    tbl[4] = '{4'b0110, 1'b1, 4'b0100, 1'b1};
    tbl[5] = '{4'b0011, 1'b1, 4'b0010, 1'b1};
    tbl[6] = '{4'b0001, 1'b1, 4'b0001, 1'b1};
    tbl[7] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[8] = '{4'b1111, 1'b0, 4'b1000, 1'b0};
    tbl[9] = '{4'b0000, 1'b0, 4'b0000, 1'b1};

    rst = 1'b1;
    req = 4'b1111;
    rtu = 1'b1;
    for (int s = 0; s < 4; s++) begin
      freg[s] = 5'(s + 1); data[s] = 32'hA000_0000 + s; ff[s] = 5'(s);
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(g), 32'd0);
    chk("rst_vld", 32'(wb_vld), 32'd0);
    chk("rst_reg", 32'(wb_reg), 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_updt", 32'(updt), 32'd0);
    chk("rst_ff", 32'(cp0_ff), 32'd0);
    req = 4'b0000;
    rtu = 1'b0;
    rst = 1'b0;

    // Directed arbitration table starting from an empty slot
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].req, tbl[i].rtu, 0);
      chk("tbl_grant", 32'(g), 32'(tbl[i].g));
      chk("tbl_vld", 32'(wb_vld), 32'(tbl[i].vld));
      tick();
    end

    // ex2 + ex4 with RTU draining: ex4 wins, its payload shows next cycle
    cyc(4'b0000, 1'b1);
    drive(4'b1010, 1'b1, 0);
    chk("ex4_over_ex2", 32'(g), 32'b1000);
    tick();
    drive(4'b0000, 1'b0, 1);
    chk("ex4_vld", 32'(wb_vld), 32'd1);
    chk("ex4_reg", 32'(wb_reg), 32'(freg[3]));
    chk("ex4_data", wb_data, data[3]);
    tick();

    // Full slot back-pressure for three cycles, then replacement by ex3
    cyc(4'b0010, 1'b1);
    drive(4'b0100, 1'b0, 0);
    sv_reg  = wb_reg;
    sv_data = wb_data;
    chk("bp_grant0", 32'(g), 32'd0);
    tick();
    for (int k = 1; k < 3; k++) begin
      drive(4'b0100, 1'b0, 1);
      chk("bp_grant", 32'(g), 32'd0);
      chk("bp_reg_hold", 32'(wb_reg), 32'(sv_reg));
      chk("bp_data_hold", wb_data, sv_data);
      tick();
    end
    drive(4'b0100, 1'b1, 1);
    chk("bp_ex3_grant", 32'(g), 32'b0100);
    tick();
    drive(4'b0000, 1'b0, 1);
    chk("bp_repl_reg", 32'(wb_reg), 32'(freg[2]));
    chk("bp_repl_data", wb_data, data[2]);
    tick();

    // fflags commit pulse one cycle after drain
    cyc(4'b0000, 1'b1);
    ff[1] = 5'b00001;
    drive(4'b0010, 1'b1, 1);
    tick();
    drive(4'b0000, 1'b1, 1);
    chk("ff_before", 32'(updt), 32'd0);
    tick();
    drive(4'b0000, 1'b0, 1);
    chk("ff_pulse", 32'(updt), 32'd1);
    chk("ff_value", 32'(cp0_ff), 32'b00001);
    tick();
    drive(4'b0000, 1'b0, 1);
    chk("ff_pulse_end", 32'(updt), 32'd0);
    chk("ff_value_end", 32'(cp0_ff), 32'd0);
    tick();

    // fdsu competing with ex2 every cycle
    cyc(4'b0000, 1'b1);
    fdsu_wins = 0;
`ifdef FPU_WBSCHED_AGING_EN
    for (int c = 1; c <= LIMIT + 1; c++) begin
      drive(4'b0011, 1'b1, 0);
      if (c <= LIMIT) chk("age_denied", 32'(fdsu_grant), 32'd0);
      else begin
        chk("age_fdsu_wins", 32'(fdsu_grant), 32'd1);
        chk("age_ex2_denied", 32'(ex2_grant), 32'd0);
      end
      tick();
    end
    drive(4'b0011, 1'b1, 0);
    chk("age_cnt_cleared", 32'(g), 32'b0010);
    tick();
`else
    for (int c = 0; c < 3 * LIMIT; c++) begin
      drive(4'b0011, 1'b1, 0);
      if (fdsu_grant) fdsu_wins++;
      tick();
    end
    chk("no_age_starve", 32'(fdsu_wins), 32'd0);
`endif
    cyc(4'b0000, 1'b1);

    // Reset in the middle of operation discards the slot entry
    cyc(4'b0100, 1'b1);
    @(negedge clk);
    #2;
    req = 4'b1111;
    rtu = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(wb_vld), 32'd0);
    chk("mid_rst_grant", 32'(g), 32'd0);
    chk("mid_rst_updt", 32'(updt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req = 4'b0000;
    rtu = 1'b0;
    rst = 1'b0;
    model_reset();
    drive(4'b0000, 1'b1, 0);
    tick();
    drive(4'b0000, 1'b1, 0);
    chk("mid_rst_no_pulse", 32'(updt), 32'd0);
    tick();
    cyc(4'b0100, 1'b0);
    drive(4'b0000, 1'b0, 0);
    chk("post_rst_accept", 32'(wb_vld), 32'd1);
    tick();

    // Randomized traffic checked against the model
    for (int c = 0; c < 400; c++) begin
      cyc(4'($urandom), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
